sram_access_seq: RTL

//  Sequencer sitting directly upstream of the DMG SRAM macro (row decoder, bit-cell array, 8 bit lanes).

---
 rtl/sram_seq_pkg.sv | 31 +++
 rtl/sram_addr_predecode.sv | 17 +
 rtl/sram_access_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sram_seq_pkg.sv
// sram_seq_pkg: shared types and constants for the SRAM access sequencer.
// Holds the phase enum, address split widths and dwell counter width.
package sram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PCH,
        ACC,
        SNS,
        ACK
    } state_t;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 2;
    localparam int COL_N  = 4;
    localparam int CNT_W  = 8;

    localparam logic [DATA_W-1:0] RD_OOR_VAL = 8'hFF;

    function automatic logic [COL_N-1:0] col_onehot(
        input logic [COL_W-1:0] sel
    );
        logic [COL_N-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sram_addr_predecode.sv
// sram_addr_predecode: splits the latched byte address into row and column.
// Row goes out true and complement; column is one-hot, forced to zero unless enabled.
module sram_addr_predecode
    import sram_seq_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              col_en,
    output logic [ROW_W-1:0]  row_d,
    output logic [ROW_W-1:0]  row_nd,
    output logic [COL_N-1:0]  col
);

    assign row_d  = addr[ADDR_W-1:COL_W];
    assign row_nd = ~addr[ADDR_W-1:COL_W];
    assign col    = col_en ? col_onehot(addr[COL_W-1:0]) : '0;

endmodule

// File: rtl/sram_access_seq.sv
// sram_access_seq: turns a req/ack byte access into SRAM macro phase strobes.
// Define SRAM_OOR_ERR_EN to add an err output flagging out-of-range accesses.
module sram_access_seq
    import sram_seq_pkg::*;
#(
    parameter int DEPTH   = 127,
    parameter int PCH_CYC = 1,
    parameter int ACC_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              n_pch,
    output logic              n_wl_pch,
    output logic              wl_ena,
    output logic [ROW_W-1:0]  row_d,
    output logic [ROW_W-1:0]  row_nd,
    output logic [COL_N-1:0]  col,
    output logic              wr,
    output logic              oe,
    output logic              n_oe,
    output logic [DATA_W-1:0] db_out,
    output logic              db_drv,
`ifdef SRAM_OOR_ERR_EN
    output logic              err,
`endif
    input  logic [DATA_W-1:0] db_in
);

    localparam int AW1 = ADDR_W + 1;

    localparam logic [CNT_W-1:0] PCH_LD  = CNT_W'(PCH_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LD  = CNT_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW1-1:0]   DEPTH_V = AW1'(DEPTH);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                accept;
    logic                col_en;
    logic                addr_ok;

    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    assign addr_ok = {1'b0, addr} < DEPTH_V;

    // Phase state and the shared PCH/ACC dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Phase sequencing and per-phase macro strobes.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        ack      = 1'b0;
        n_pch    = 1'b1;
        n_wl_pch = 1'b1;
        wl_ena   = 1'b0;
        col_en   = 1'b0;
        wr       = 1'b0;
        oe       = 1'b0;
        db_drv   = 1'b0;
        db_out   = '0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (addr_ok) begin
                        state_nx = PCH;
                        cnt_nx   = PCH_LD;
                    end else begin
                        state_nx = ACK;
                    end
                end
            end
            PCH: begin
                n_pch    = 1'b0;
                n_wl_pch = 1'b0;
                if (cnt == '0) begin
                    state_nx = ACC;
                    cnt_nx   = ACC_LD;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            ACC: begin
                wl_ena = 1'b1;
                col_en = 1'b1;
                wr     = we_q;
                db_drv = we_q;
                db_out = we_q ? wdata_q : '0;
                if (cnt == '0) begin
                    state_nx = we_q ? ACK : SNS;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end
            SNS: begin
                wl_ena   = 1'b1;
                col_en   = 1'b1;
                oe       = 1'b1;
                state_nx = ACK;
            end
            ACK: begin
                ack      = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request latch at acceptance and read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
                if (!addr_ok && !we) begin
                    rdata_q <= RD_OOR_VAL;
                end
            end
            if (state == SNS) begin
                rdata_q <= db_in;
            end
        end
    end

`ifdef SRAM_OOR_ERR_EN
    logic oor_q;

    // Remembers that the access in flight missed the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (accept) begin
            oor_q <= !addr_ok;
        end
    end

    assign err = (state == ACK) && oor_q;
`endif

    assign rdata = rdata_q;
    assign n_oe  = ~oe;

    sram_addr_predecode u_predecode (
        .addr   (addr_q),
        .col_en (col_en),
        .row_d  (row_d),
        .row_nd (row_nd),
        .col    (col)
    );

endmodule
